// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter sharing one register-file read/write port among requesters.
// Optional build macro: REGFILE_ARB_WRITE_PRIORITY_EN (valid writes pre-empt reads).
module regfile_port_arbiter #(
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_REGISTERS  = 3,
   parameter int NUM_REQUESTERS = 4,
   parameter int ADDR_WIDTH     = 2
) (
   input  logic                                 clk_i,
   input  logic                                 reset_n_i,
   input  logic [NUM_REQUESTERS-1:0]            req_valid_i,
   input  logic [NUM_REQUESTERS-1:0]            req_write_i,
   input  logic [NUM_REQUESTERS*ADDR_WIDTH-1:0] req_addr_i,
   input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] req_data_i,
   output logic [NUM_REQUESTERS-1:0]            req_ready_o,
   output logic [NUM_REQUESTERS-1:0]            rsp_valid_o,
   output logic [DATA_WIDTH-1:0]                rsp_data_o,
   output logic [NUM_REGISTERS-1:0]             rf_select_o,
   output logic                                 rf_write_o,
   output logic [DATA_WIDTH-1:0]                rf_data_o,
   input  logic [DATA_WIDTH-1:0]                rf_data_i
);

   localparam int PTR_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

   // Handshake: a request is accepted in a cycle where req_valid_i[k] and
   // req_ready_o[k] are both 1; responses have no ready and are never stalled.

   logic [PTR_W-1:0]          r_ptr;
   logic [NUM_REQUESTERS-1:0] r_rsp_valid;
   logic [DATA_WIDTH-1:0]     r_rsp_data;

   logic [NUM_REQUESTERS-1:0] w_eligible;
   logic [NUM_REQUESTERS-1:0] w_grant;
   logic [PTR_W-1:0]          w_win;
   logic [PTR_W-1:0]          w_ptr_next;
   logic                      w_found;
   logic                      w_gnt_en;
   logic                      w_win_write;
   logic [ADDR_WIDTH-1:0]     w_addr;
   logic                      w_in_range;
   logic [DATA_WIDTH-1:0]     w_wdata;

`ifdef REGFILE_ARB_WRITE_PRIORITY_EN
   logic w_any_write;
   assign w_any_write = |(req_valid_i & req_write_i);
   assign w_eligible  = w_any_write ? (req_valid_i & req_write_i) : req_valid_i;
`else
   assign w_eligible  = req_valid_i;
`endif

   // Cyclic search starting at r_ptr; first eligible requester wins.
   always_comb begin
      int idx;
      idx     = 0;
      w_found = 1'b0;
      w_win   = '0;
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
         idx = int'(r_ptr) + i;
         if (idx >= NUM_REQUESTERS) idx = idx - NUM_REQUESTERS;
         if (!w_found && w_eligible[idx]) begin
            w_found = 1'b1;
            w_win   = PTR_W'(idx);
         end
      end
   end

   assign w_gnt_en    = w_found & reset_n_i;
   assign w_grant     = w_gnt_en ? (NUM_REQUESTERS'(1) << w_win) : '0;
   assign w_win_write = req_write_i[w_win];
   assign w_addr      = req_addr_i[w_win*ADDR_WIDTH +: ADDR_WIDTH];
   assign w_wdata     = req_data_i[w_win*DATA_WIDTH +: DATA_WIDTH];
   assign w_in_range  = (int'(w_addr) < NUM_REGISTERS);
   assign w_ptr_next  = (int'(w_win) == NUM_REQUESTERS - 1) ? '0 : w_win + PTR_W'(1);

   assign req_ready_o = w_grant;
   assign rf_select_o = (w_gnt_en && w_in_range) ? (NUM_REGISTERS'(1) << w_addr) : '0;
   assign rf_write_o  = w_gnt_en & w_in_range & w_win_write;
   assign rf_data_o   = w_gnt_en ? w_wdata : '0;

   // Out-of-range reads return zero rather than whatever the unselected port drives.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_ptr       <= '0;
         r_rsp_valid <= '0;
         r_rsp_data  <= '0;
      end else begin
         if (w_gnt_en) r_ptr <= w_ptr_next;
         r_rsp_valid <= (w_gnt_en && !w_win_write) ? w_grant : '0;
         if (w_gnt_en && !w_win_write) r_rsp_data <= w_in_range ? rf_data_i : '0;
      end
   end

   assign rsp_valid_o = r_rsp_valid;
   assign rsp_data_o  = r_rsp_data;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a small behavioural register file.
// Honours REGFILE_ARB_WRITE_PRIORITY_EN for the simultaneous read/write case.
module tb_regfile_port_arbiter;

   localparam int DW = 32;
   localparam int NR = 3;
   localparam int NQ = 4;
   localparam int AW = 2;

   logic             clk_i = 1'b0;
   logic             reset_n_i;
   logic [NQ-1:0]    req_valid_i;
   logic [NQ-1:0]    req_write_i;
   logic [NQ*AW-1:0] req_addr_i;
   logic [NQ*DW-1:0] req_data_i;
   logic [NQ-1:0]    req_ready_o;
   logic [NQ-1:0]    rsp_valid_o;
   logic [DW-1:0]    rsp_data_o;
   logic [NR-1:0]    rf_select_o;
   logic             rf_write_o;
   logic [DW-1:0]    rf_data_o;
   logic [DW-1:0]    rf_data_i;

   int n_checks = 0;
   int n_errs   = 0;
   logic [DW-1:0] exp_q[$];

   always #5 clk_i = ~clk_i;

   regfile_port_arbiter #(
      .DATA_WIDTH(DW), .NUM_REGISTERS(NR), .NUM_REQUESTERS(NQ), .ADDR_WIDTH(AW)
   ) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i),
      .req_valid_i(req_valid_i), .req_write_i(req_write_i),
      .req_addr_i(req_addr_i), .req_data_i(req_data_i),
      .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
      .rf_select_o(rf_select_o), .rf_write_o(rf_write_o), .rf_data_o(rf_data_o),
      .rf_data_i(rf_data_i)
   );

   // Register file: combinational read, write on clock edge, junk when nothing selected.
   logic [DW-1:0] regs [NR] = '{32'h1000_0000, 32'h2000_0001, 32'h3000_0002};

   always @(posedge clk_i) begin
      if (rf_write_o) begin
         case (rf_select_o)
            3'b001:  regs[0] <= rf_data_o;
            3'b010:  regs[1] <= rf_data_o;
            3'b100:  regs[2] <= rf_data_o;
            default: ;
         endcase
      end
   end

   always_comb begin
      case (rf_select_o)
         3'b001:  rf_data_i = regs[0];
         3'b010:  rf_data_i = regs[1];
         3'b100:  rf_data_i = regs[2];
         default: rf_data_i = 32'hBAD0_BAD0;
      endcase
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input int k, input logic v, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid_i[k]         = v;
      req_write_i[k]         = w;
      req_addr_i[k*AW +: AW] = a;
      req_data_i[k*DW +: DW] = d;
   endtask

   task automatic clear_all();
      for (int k = 0; k < NQ; k++) drive(k, 1'b0, 1'b0, '0, '0);
   endtask

   initial begin
      logic [DW-1:0] rr_data [3];
      int w;
      rr_data = '{32'h1000_0000, 32'hDEAD_BEEF, 32'h3000_0002};

      // Reset with requests present: grant path must be forced low.
      reset_n_i   = 1'b0;
      req_write_i = '0;
      req_addr_i  = '0;
      req_data_i  = '0;
      req_valid_i = 4'b1111;
      #1;
      check("rst_ready",     req_ready_o, 4'b0000);
      check("rst_select",    rf_select_o, 3'b000);
      check("rst_write",     rf_write_o,  1'b0);
      check("rst_rsp_valid", rsp_valid_o, 4'b0000);
      check("rst_rsp_data",  rsp_data_o,  32'h0);
      req_valid_i = '0;
      #9;
      reset_n_i = 1'b1;
      #1;
      check("idle_ready",   req_ready_o, 4'b0000);
      check("idle_select",  rf_select_o, 3'b000);
      check("idle_rf_data", rf_data_o,   32'h0);
      check("idle_rsp",     rsp_valid_o, 4'b0000);
      step();

      // Requester 2 writes reg 1, then requester 0 reads it back.
      drive(2, 1'b1, 1'b1, 2'd1, 32'hDEAD_BEEF);
      #1;
      check("wr_ready",   req_ready_o, 4'b0100);
      check("wr_select",  rf_select_o, 3'b010);
      check("wr_strobe",  rf_write_o,  1'b1);
      check("wr_rf_data", rf_data_o,   32'hDEAD_BEEF);
      step();
      check("wr_no_rsp", rsp_valid_o, 4'b0000);
      drive(2, 1'b0, 1'b0, 2'd0, 32'h0);
      drive(0, 1'b1, 1'b0, 2'd1, 32'h0);
      #1;
      check("rd_ready",  req_ready_o, 4'b0001);
      check("rd_select", rf_select_o, 3'b010);
      check("rd_strobe", rf_write_o,  1'b0);
      step();
      check("rd_rsp_valid", rsp_valid_o, 4'b0001);
      check("rd_rsp_data",  rsp_data_o,  32'hDEAD_BEEF);
      clear_all();

      // Fresh reset, then all four read continuously: grants 0,1,2,3,0.
      reset_n_i = 1'b0;
      #1;
      reset_n_i = 1'b1;
      for (int k = 0; k < NQ; k++) drive(k, 1'b1, 1'b0, AW'(k % 3), 32'h0);
      for (int i = 0; i < 5; i++) begin
         w = i % NQ;
         #1;
         check("rr_grant", req_ready_o, 64'(1) << w);
         exp_q.push_back(rr_data[w % 3]);
         step();
         check("rr_rsp_valid", rsp_valid_o, 64'(1) << w);
         check("rr_rsp_data",  rsp_data_o,  exp_q.pop_front());
      end
      clear_all();
      #1;
      check("rr_idle_ready", req_ready_o, 4'b0000);
      step();
      check("rr_idle_rsp", rsp_valid_o, 4'b0000);

      // Out-of-range address: granted, nothing selected, reads return zero.
      drive(1, 1'b1, 1'b0, 2'd3, 32'h0);
      #1;
      check("oor_rd_ready",  req_ready_o, 4'b0010);
      check("oor_rd_select", rf_select_o, 3'b000);
      step();
      check("oor_rd_rsp_valid", rsp_valid_o, 4'b0010);
      check("oor_rd_rsp_data",  rsp_data_o,  32'h0);
      drive(1, 1'b1, 1'b1, 2'd3, 32'h5555_5555);
      #1;
      check("oor_wr_ready",  req_ready_o, 4'b0010);
      check("oor_wr_select", rf_select_o, 3'b000);
      check("oor_wr_strobe", rf_write_o,  1'b0);
      step();
      check("oor_wr_no_rsp", rsp_valid_o, 4'b0000);
      clear_all();

      // Simultaneous read (0) and write (3) with ptr at 0.
      reset_n_i = 1'b0;
      #1;
      reset_n_i = 1'b1;
      drive(0, 1'b1, 1'b0, 2'd0, 32'h0);
      drive(3, 1'b1, 1'b1, 2'd2, 32'hCAFE_F00D);
      #1;
`ifdef REGFILE_ARB_WRITE_PRIORITY_EN
      check("prio_first", req_ready_o, 4'b1000);
      step();
      check("prio_first_rsp", rsp_valid_o, 4'b0000);
      drive(3, 1'b0, 1'b0, 2'd0, 32'h0);
      #1;
      check("prio_second", req_ready_o, 4'b0001);
      step();
      check("prio_second_rsp",  rsp_valid_o, 4'b0001);
      check("prio_second_data", rsp_data_o,  32'h1000_0000);
`else
      check("prio_first", req_ready_o, 4'b0001);
      step();
      check("prio_first_rsp",  rsp_valid_o, 4'b0001);
      check("prio_first_data", rsp_data_o,  32'h1000_0000);
      drive(0, 1'b0, 1'b0, 2'd0, 32'h0);
      #1;
      check("prio_second", req_ready_o, 4'b1000);
      step();
      check("prio_second_rsp", rsp_valid_o, 4'b0000);
`endif
      clear_all();

      // Read granted, reset pulsed mid-response cycle: response dropped, ptr back to 0.
      drive(2, 1'b1, 1'b0, 2'd2, 32'h0);
      #1;
      check("mr_ready", req_ready_o, 4'b0100);
      step();
      check("mr_rsp_valid", rsp_valid_o, 4'b0100);
      check("mr_rsp_data",  rsp_data_o,  32'hCAFE_F00D);
      drive(2, 1'b0, 1'b0, 2'd0, 32'h0);
      #1;
      reset_n_i = 1'b0;
      #1;
      check("mr_rsp_dropped", rsp_valid_o, 4'b0000);
      check("mr_rsp_data0",   rsp_data_o,  32'h0);
      #1;
      reset_n_i = 1'b1;
      drive(1, 1'b1, 1'b0, 2'd0, 32'h0);
      drive(3, 1'b1, 1'b0, 2'd0, 32'h0);
      #1;
      check("mr_next_grant", req_ready_o, 4'b0010);
      step();
      check("mr_next_rsp",  rsp_valid_o, 4'b0010);
      check("mr_next_data", rsp_data_o,  32'h1000_0000);
      clear_all();
      step();

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

// File: doc/regfile_port_arbiter.md
# regfile_port_arbiter

Round-robin arbiter that shares one read/write port of the register file among several requesters. It sits between the requesters (decode, cache-control, debug) and the register file port. Each cycle it accepts at most one request, drives one-hot register select and write strobe toward the register file, and returns read data to the winning requester one cycle later.

## Interface
- DATA_WIDTH, 32, register width in bits
- NUM_REGISTERS, 3, registers behind the port; select output is one-hot of this width
- NUM_REQUESTERS, 4, requester count (≥1)
- ADDR_WIDTH, 2, register index width; must satisfy 2^ADDR_WIDTH ≥ NUM_REGISTERS
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous, active-low reset
- req_valid_i  in  NUM_REQUESTERS  request pending, one bit per requester k
- req_write_i  in  NUM_REQUESTERS  1 = write, 0 = read
- req_addr_i  in  NUM_REQUESTERS*ADDR_WIDTH  register index; requester k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- req_data_i  in  NUM_REQUESTERS*DATA_WIDTH  write data; requester k uses bits [k*DATA_WIDTH +: DATA_WIDTH]
- req_ready_o  out  NUM_REQUESTERS  one-hot grant; the request is accepted in a cycle where valid and ready are both 1
- rsp_valid_o  out  NUM_REQUESTERS  one-hot read-response strobe
- rsp_data_o  out  DATA_WIDTH  read data, shared by all requesters
- rf_select_o  out  NUM_REGISTERS  one-hot register select toward the register file
- rf_write_o  out  1  write strobe toward the register file
- rf_data_o  out  DATA_WIDTH  write data toward the register file
- rf_data_i  in  DATA_WIDTH  data read from the selected register (combinational in the register file)

## Operation
- Priority pointer ptr (clog2(NUM_REQUESTERS) bits): requester ptr has highest priority, followed by ptr+1, and so on cyclically.
- Winner selection:
  - The winner is the first requester with valid=1, searched from ptr upward modulo NUM_REQUESTERS.
  - req_ready_o is one-hot for the winner. It is all-zero when no request is valid.
- On a grant to requester w, ptr is set to (w+1) mod NUM_REQUESTERS at the next clock edge. With no grant, ptr holds.
- Register-file drive during a grant:
  - rf_select_o is one-hot at bit addr_w.
  - rf_write_o equals req_write_i[w].
  - rf_data_o equals the data slice of w.
- Register-file drive with no grant: rf_select_o, rf_write_o and rf_data_o are all zero.
- Out-of-range address (addr ≥ NUM_REGISTERS):
  - The request is still granted.
  - rf_select_o is all-zero and rf_write_o is 0, so no register changes.
  - A read returns 0.
- Read response: the arbiter registers rf_data_i and the winner's id. rsp_valid_o[w] is 1 for exactly one cycle and carries the data.
- Write: no response is generated.
- Ordering is strict grant order. A read granted in the cycle after a write to the same register returns the new value.
- Pointer update and response registers are the only state. The block never stalls, so there is no backpressure on responses.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert assumed at the system level):
  - ptr is 0, rsp_valid_o is 0 and rsp_data_o is 0.
  - req_ready_o, rf_select_o and rf_write_o are forced to 0 while reset_n_i is low.
- Grant path is combinational: req_ready_o and the rf_* outputs follow the req_* inputs in the same cycle T.
- Write latency: the register file captures the write at the edge ending cycle T.
- Read latency is 1 cycle: rsp_valid_o and rsp_data_o are valid in T+1 for one cycle.
- Throughput: one request per cycle, reads and writes interleaved freely.
- Reset asserted mid-operation: a pending response in T+1 is dropped (rsp_valid_o goes to 0), and ptr returns to 0.
- Fairness: a requester that holds valid is granted within NUM_REQUESTERS cycles.

## Configuration
- REGFILE_ARB_WRITE_PRIORITY_EN defined:
  - When any write request is valid, only writes compete; the round-robin search runs over writers only.
  - Reads are granted only in cycles with no valid write, so reads may starve under continuous writes.
  - ptr updates identically on every grant.
- REGFILE_ARB_WRITE_PRIORITY_EN undefined: pure round-robin over all requesters regardless of request type.

## Test plan
- Reset, then all valid=0 → req_ready_o=0000, rf_select_o=000, rsp_valid_o=0000.
- Requester 2 writes 0xDEADBEEF to reg 1 in cycle T, requester 0 reads reg 1 in T+1 → rf_select_o=010 and rf_write_o=1 in T; rsp_valid_o=0001 and rsp_data_o=0xDEADBEEF in T+2.
- All four requesters hold valid reads continuously from reset → grants 0,1,2,3,0 on consecutive cycles; each rsp_valid_o bit pulses one cycle after its grant.
- Requester 1 reads address 3 (NUM_REGISTERS=3) → granted, rf_select_o=000, rsp_data_o=0 in the next cycle.
- Requester 0 reads and requester 3 writes simultaneously with ptr=0 → without the macro, requester 0 wins first, then requester 3. With REGFILE_ARB_WRITE_PRIORITY_EN, requester 3 wins first, then requester 0.
- Read granted in T, reset_n_i pulsed low mid-T+1 → rsp_valid_o=0 immediately, ptr=0, and the next grant goes to the lowest valid index.
